button_press_fsm: RTL and testbench



---
 rtl/button_press_fsm.sv | 149 ++++++++++++++
 tb/tb_button_press_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_press_fsm.sv
// button_press_fsm: turns a debounced button level into single-cycle events
// (press, short press, long press, auto-repeat, release) plus a held level.
// All outputs are registered. Reset is synchronous and active-high.
// Optional feature macro: AUTO_REPEAT_EN. When it is defined, HELD emits
// periodic repeat/step pulses. When it is undefined, repeat stays 0, step
// equals press, and the counter stays at 0 in HELD.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | button released, waiting for a press
// PRESSED | button down, counting toward the long-press threshold
// HELD    | long press reached, waiting for release (auto-repeat if enabled)

module button_press_fsm #(
  parameter int LONG_TIME   = 99999999,
  parameter int REPEAT_TIME = 24999999
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_debounced,
  output logic o_press,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_release,
  output logic o_step,
  output logic o_held
);

  localparam logic [26:0] LONG_TC   = 27'(LONG_TIME - 1);
  localparam logic [26:0] REPEAT_TC = 27'(REPEAT_TIME - 1);

  // Reject thresholds that the 27-bit counter cannot represent.
  if (LONG_TIME < 2 || LONG_TIME > 134217727 ||
      REPEAT_TIME < 1 || REPEAT_TIME > 134217727) begin : g_bad_params
    $error("button_press_fsm: LONG_TIME or REPEAT_TIME out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [26:0] r_count, w_count_nxt;
  logic        r_press, r_short_press, r_long_press, r_repeat;
  logic        r_release, r_step, r_held;
  logic        w_press_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt;
  logic        w_release_nxt, w_step_nxt, w_held_nxt;

  // State, counter and output registers; reset overrides every other event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_press       <= 1'b0;
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
      r_repeat      <= 1'b0;
      r_release     <= 1'b0;
      r_step        <= 1'b0;
      r_held        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_press       <= w_press_nxt;
      r_short_press <= w_short_nxt;
      r_long_press  <= w_long_nxt;
      r_repeat      <= w_repeat_nxt;
      r_release     <= w_release_nxt;
      r_step        <= w_step_nxt;
      r_held        <= w_held_nxt;
    end
  end

  // Next-state, counter and pulse decode; release is checked before the
  // terminal count so a release on that edge suppresses long/repeat.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_press_nxt   = 1'b0;
    w_short_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_debounced) begin
          w_press_nxt = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!i_debounced) begin
          w_release_nxt = 1'b1;
          w_short_nxt   = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (r_count == LONG_TC) begin
          w_long_nxt  = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = ST_HELD;
        end else begin
          w_count_nxt = r_count + 27'd1;
        end
      end
      ST_HELD: begin
        if (!i_debounced) begin
          w_release_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (r_count == REPEAT_TC) begin
            w_repeat_nxt = 1'b1;
            w_count_nxt  = '0;
          end else begin
            w_count_nxt = r_count + 27'd1;
          end
`else
          w_count_nxt = '0;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
    w_step_nxt = w_press_nxt | w_repeat_nxt;
    // held stays high through the cycle that carries the release pulse.
    w_held_nxt = (w_state_nxt != ST_IDLE) | w_release_nxt;
  end

`ifndef AUTO_REPEAT_EN
  // Without auto-repeat the repeat terminal count is never compared.
  logic [26:0] w_repeat_tc_unused;
  assign w_repeat_tc_unused = REPEAT_TC;
`endif

  assign o_press       = r_press;
  assign o_short_press = r_short_press;
  assign o_long_press  = r_long_press;
  assign o_repeat      = r_repeat;
  assign o_release     = r_release;
  assign o_step        = r_step;
  assign o_held        = r_held;

endmodule

// File: tb/tb_button_press_fsm.sv
// Directed bench for button_press_fsm with LONG_TIME=10, REPEAT_TIME=4.
// Output vector order: {press, short_press, long_press, repeat, release, step, held}.

module tb_button_press_fsm;

  logic clk = 1'b0;
  logic rst;
  logic debounced;
  logic press, short_press, long_press, rpt, rel, step, held;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_PRESS = 7'b1000011;
  localparam logic [6:0] O_HELD  = 7'b0000001;
  localparam logic [6:0] O_SHORT = 7'b0100101;
  localparam logic [6:0] O_LONG  = 7'b0010001;
  localparam logic [6:0] O_RPT   = 7'b0001011;
  localparam logic [6:0] O_REL   = 7'b0000101;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  button_press_fsm #(.LONG_TIME(10), .REPEAT_TIME(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_debounced   (debounced),
    .o_press       (press),
    .o_short_press (short_press),
    .o_long_press  (long_press),
    .o_repeat      (rpt),
    .o_release     (rel),
    .o_step        (step),
    .o_held        (held)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int idx, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {press, short_press, long_press, rpt, rel, step, held};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [6:0] hold_exp(input int i);
    if (i == 1) return O_PRESS;
    if (i == 11) return O_LONG;
    if (AUTO && i > 11 && ((i - 11) % 4) == 0) return O_RPT;
    return O_HELD;
  endfunction

  initial begin
    rst = 1'b1;
    debounced = 1'b1;
    @(negedge clk);

    // Reset with button down: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset", i, O_NONE);
    end
    rst = 1'b0;
    cyc();
    chk("press_after_reset", 0, O_PRESS);
    debounced = 1'b0;
    cyc();
    chk("rel_after_reset", 0, O_SHORT);
    cyc();
    chk("idle_after_reset", 0, O_NONE);

    // Short tap: 5 sampled-high edges.
    debounced = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("tap", i, (i == 1) ? O_PRESS : O_HELD);
    end
    debounced = 1'b0;
    cyc();
    chk("tap_release", 0, O_SHORT);
    cyc();
    chk("tap_idle", 0, O_NONE);

    // Long hold for 30 cycles: long at T+10, repeats at T+14/18/22/26.
    debounced = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      chk("long", i, hold_exp(i));
    end
    debounced = 1'b0;
    cyc();
    chk("long_release", 0, O_REL);
    cyc();
    chk("long_idle", 0, O_NONE);

    // Release on the edge where count==LONG_TIME-1: short wins, no long.
    debounced = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("edge_long", i, (i == 1) ? O_PRESS : O_HELD);
    end
    debounced = 1'b0;
    cyc();
    chk("edge_long_release", 0, O_SHORT);
    cyc();
    chk("edge_long_idle", 0, O_NONE);

    // Release on the edge of the first repeat terminal: no repeat pulse.
    debounced = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      chk("edge_rpt", i, hold_exp(i));
    end
    debounced = 1'b0;
    cyc();
    chk("edge_rpt_release", 0, O_REL);
    cyc();
    chk("edge_rpt_idle", 0, O_NONE);

    // Reset at T+12 while held: no release, fresh press after reset.
    debounced = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("midrst_hold", i, hold_exp(i));
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("midrst_reset", i, O_NONE);
    end
    rst = 1'b0;
    cyc();
    chk("midrst_repress", 0, O_PRESS);
    cyc();
    chk("midrst_held", 0, O_HELD);
    debounced = 1'b0;
    cyc();
    chk("midrst_release", 0, O_SHORT);
    cyc();
    chk("midrst_idle", 0, O_NONE);

    // Back-to-back presses at the 2-cycle minimum spacing.
    for (int k = 0; k < 2; k++) begin
      debounced = 1'b1;
      cyc();
      chk("repress_press", k, O_PRESS);
      debounced = 1'b0;
      cyc();
      chk("repress_release", k, O_SHORT);
    end
    cyc();
    chk("repress_idle", 0, O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
